vga_frame_scanner: RTL and testbench

//  Display stage downstream of procesadorArm: scans a 640x480@60 frame and fetches

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_frame_scanner_if.sv | 27 ++
 rtl/vga_sync_counter.sv | 74 +++++++
 rtl/vga_frame_scanner.sv | 103 ++++++++++
 tb/tb_vga_frame_scanner.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and colour helpers for the VGA frame scanner.
// Totals and sync windows describe the default 640x480@60 mode.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SW     = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SW     = 2;
  localparam int V_BP     = 33;
  localparam int SCALE_SH = 2;
  localparam int ADDR_W   = 15;
  localparam int PIX_W    = 8;
  localparam int CNT_W    = 10;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SW + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SW;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SW;
  localparam int IMG_W        = H_ACTIVE >> SCALE_SH;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps full-scale codes at 0x00 and 0xFF.
  function automatic rgb888_t rgb332_to_rgb888(input logic [PIX_W-1:0] p);
    rgb888_t c;
    c.r = {p[7:5], p[7:5], p[7:6]};
    c.g = {p[4:2], p[4:2], p[4:3]};
    c.b = {4{p[1:0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_scanner_if.sv
// Frame-memory read port plus DAC pins of the scanner; master = scanner side.
interface vga_frame_scanner_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              clk_25;
  logic              H_SYNC;
  logic              V_SYNC;
  logic              SYNC_B;
  logic              SYNC_BLANK;
  logic              frame_start;

  modport master (
    output mem_addr, r, g, b, clk_25, H_SYNC, V_SYNC, SYNC_B, SYNC_BLANK, frame_start,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, r, g, b, clk_25, H_SYNC, V_SYNC, SYNC_B, SYNC_BLANK, frame_start,
    output mem_rdata
  );

endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-tick generator and raster counters; produces the stage-0 active/sync
// flags and a one-clock pulse whenever the scan enters (0,0).
module vga_sync_counter import vga_pkg::*; #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SW     = vga_pkg::H_SW,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SW     = vga_pkg::V_SW,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic             adv,
  output logic             line_end,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active0,
  output logic             hs0,
  output logic             vs0,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SW + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SW + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SW);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SW);

  logic running;

  assign adv      = tick & running;
  assign line_end = adv && (hcnt == H_LAST);

  // The first pixel tick after reset only enters (0,0) so frame_start fires there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick        <= 1'b0;
      running     <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      tick        <= ~tick;
      frame_start <= 1'b0;
      if (tick && !running) begin
        running     <= 1'b1;
        frame_start <= 1'b1;
      end else if (adv) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          if (vcnt == V_LAST) begin
            vcnt        <= '0;
            frame_start <= 1'b1;
          end else begin
            vcnt <= vcnt + 1'b1;
          end
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  assign active0 = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
  assign hs0     = !((hcnt >= HS_START) && (hcnt < HS_END));
  assign vs0     = !((vcnt >= VS_START) && (vcnt < VS_END));

endmodule

// File: rtl/vga_frame_scanner.sv
// Scans the frame, fetches scaled image pixels from frame memory and drives the
// DAC with RGB888 colour and syncs, two pixel ticks behind the raster counters.
module vga_frame_scanner import vga_pkg::*; #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SW     = vga_pkg::H_SW,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SW     = vga_pkg::V_SW,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                clk,
  input  logic                rst,
  vga_frame_scanner_if.master vga
);

  localparam int               IMG_WIDTH = H_ACTIVE >> SCALE_SH;
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SW + V_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);

  logic             tick;
  logic             adv;
  logic             line_end;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W-1:0] vnext;
  logic             active0;
  logic             hs0;
  logic             vs0;
  logic             frame_start;
  logic             act1;
  logic             hs1;
  logic             vs1;
  logic [ADDR_W-1:0] row_base;
  rgb888_t          pix;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SW (H_SW), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SW (V_SW), .V_BP (V_BP)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .adv         (adv),
    .line_end    (line_end),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .active0     (active0),
    .hs0         (hs0),
    .vs0         (vs0),
    .frame_start (frame_start)
  );

  assign vnext = vcnt + 1'b1;
  assign pix   = rgb332_to_rgb888(vga.mem_rdata);

  // row_base tracks (vcnt >> SCALE_SH) * IMG_WIDTH incrementally, avoiding a multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
    end else if (line_end) begin
      if (vcnt == V_LAST) begin
        row_base <= '0;
      end else if ((vnext[SCALE_SH-1:0] == '0) && (vnext < V_ACT_C)) begin
        row_base <= row_base + ADDR_W'(IMG_WIDTH);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga.mem_addr   <= '0;
      act1           <= 1'b0;
      hs1            <= 1'b1;
      vs1            <= 1'b1;
      vga.r          <= 8'h00;
      vga.g          <= 8'h00;
      vga.b          <= 8'h00;
      vga.H_SYNC     <= 1'b1;
      vga.V_SYNC     <= 1'b1;
      vga.SYNC_BLANK <= 1'b0;
    end else if (adv) begin
      if (active0) begin
        vga.mem_addr <= row_base + ADDR_W'(hcnt >> SCALE_SH);
      end
      act1           <= active0;
      hs1            <= hs0;
      vs1            <= vs0;
      vga.H_SYNC     <= hs1;
      vga.V_SYNC     <= vs1;
      vga.SYNC_BLANK <= act1;
      vga.r          <= act1 ? pix.r : 8'h00;
      vga.g          <= act1 ? pix.g : 8'h00;
      vga.b          <= act1 ? pix.b : 8'h00;
    end
  end

  assign vga.clk_25      = tick;
  assign vga.SYNC_B      = 1'b0;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: a full-size instance and a miniature-timing instance,
// both compared every clock against a raster model computed from elapsed clocks.
module tb_vga_frame_scanner;
  import vga_pkg::*;

  typedef struct packed {
    int h_act; int h_fp; int h_sw; int h_bp;
    int v_act; int v_fp; int v_sw; int v_bp;
  } cfg_t;

  typedef struct {
    bit clk25; bit hs; bit vs; bit vis; bit fs; bit addr_known;
    int addr; int r; int g; int b;
  } exp_t;

  localparam cfg_t CFG_A = '{h_act:640, h_fp:16, h_sw:96, h_bp:48,
                             v_act:480, v_fp:10, v_sw:2,  v_bp:33};
  localparam cfg_t CFG_B = '{h_act:32,  h_fp:4,  h_sw:8,  h_bp:4,
                             v_act:16,  v_fp:2,  v_sw:2,  v_bp:3};
  localparam int IMG_WORDS = 19200;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n_a = 0;
  int   n_b = 0;
  logic [7:0] image [IMG_WORDS];

  vga_frame_scanner_if bus_a ();
  vga_frame_scanner_if bus_b ();

  vga_frame_scanner dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (bus_a.master)
  );

  vga_frame_scanner #(
    .H_ACTIVE (CFG_B.h_act), .H_FP (CFG_B.h_fp), .H_SW (CFG_B.h_sw), .H_BP (CFG_B.h_bp),
    .V_ACTIVE (CFG_B.v_act), .V_FP (CFG_B.v_fp), .V_SW (CFG_B.v_sw), .V_BP (CFG_B.v_bp)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (bus_b.master)
  );

  always #10 clk = ~clk;

  // Frame memories answer one clock after the address, i.e. within one pixel tick.
  always @(posedge clk)
    bus_a.mem_rdata <= (bus_a.mem_addr < ADDR_W'(IMG_WORDS)) ? image[bus_a.mem_addr] : 8'h00;
  always @(posedge clk)
    bus_b.mem_rdata <= (bus_b.mem_addr < ADDR_W'(IMG_WORDS)) ? image[bus_b.mem_addr] : 8'h00;

  always @(posedge clk or posedge rst_a)
    if (rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or posedge rst_b)
    if (rst_b) n_b <= 0; else n_b <= n_b + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  // n = clocks since reset release; pixel p is on the counters after clock 2p+2
  // and reaches the pins two pixel ticks later.
  function automatic exp_t expectPins(input cfg_t c, input int n);
    exp_t e;
    int h_tot, v_tot, p, q, h, v, pix;
    h_tot = c.h_act + c.h_fp + c.h_sw + c.h_bp;
    v_tot = c.v_act + c.v_fp + c.v_sw + c.v_bp;
    e.clk25 = (n % 2) == 1;
    e.hs = 1'b1; e.vs = 1'b1; e.vis = 1'b0; e.fs = 1'b0;
    e.r = 0; e.g = 0; e.b = 0;
    e.addr_known = (n < 4);
    e.addr = 0;
    if (n >= 2) begin
      p = (n - 2) / 2;
      e.fs = ((n % 2) == 0) && ((p % (h_tot * v_tot)) == 0);
      if (p >= 1) begin
        h = (p - 1) % h_tot;
        v = ((p - 1) / h_tot) % v_tot;
        if (h < c.h_act && v < c.v_act) begin
          e.addr_known = 1'b1;
          e.addr = (v / 4) * (c.h_act / 4) + h / 4;
        end
      end
      if (p >= 2) begin
        q = p - 2;
        h = q % h_tot;
        v = (q / h_tot) % v_tot;
        e.vis = (h < c.h_act) && (v < c.v_act);
        e.hs = !(h >= c.h_act + c.h_fp && h < c.h_act + c.h_fp + c.h_sw);
        e.vs = !(v >= c.v_act + c.v_fp && v < c.v_act + c.v_fp + c.v_sw);
        if (e.vis) begin
          pix = int'(image[(v / 4) * (c.h_act / 4) + h / 4]);
          e.r = (((pix >> 5) & 7) * 255 + 3) / 7;
          e.g = (((pix >> 2) & 7) * 255 + 3) / 7;
          e.b = (pix & 3) * 85;
        end
      end
    end
    return e;
  endfunction

  task automatic checkPins(input string tag, input exp_t e,
                           input logic clk25, input logic hs, input logic vs,
                           input logic sync_b, input logic vis, input logic fs,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic [ADDR_W-1:0] addr);
    checkOutput({tag, ".clk_25"},      32'(clk25),  32'(e.clk25));
    checkOutput({tag, ".H_SYNC"},      32'(hs),     32'(e.hs));
    checkOutput({tag, ".V_SYNC"},      32'(vs),     32'(e.vs));
    checkOutput({tag, ".SYNC_B"},      32'(sync_b), 32'd0);
    checkOutput({tag, ".SYNC_BLANK"},  32'(vis),    32'(e.vis));
    checkOutput({tag, ".frame_start"}, 32'(fs),     32'(e.fs));
    checkOutput({tag, ".r"},           32'(r),      e.r);
    checkOutput({tag, ".g"},           32'(g),      e.g);
    checkOutput({tag, ".b"},           32'(b),      e.b);
    checkOutput({tag, ".addr_range"},  32'(addr < ADDR_W'(IMG_WORDS)), 32'd1);
    if (e.addr_known) checkOutput({tag, ".mem_addr"}, 32'(addr), e.addr);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkPins("A", expectPins(CFG_A, n_a), bus_a.clk_25, bus_a.H_SYNC, bus_a.V_SYNC,
                bus_a.SYNC_B, bus_a.SYNC_BLANK, bus_a.frame_start,
                bus_a.r, bus_a.g, bus_a.b, bus_a.mem_addr);
      checkPins("B", expectPins(CFG_B, n_b), bus_b.clk_25, bus_b.H_SYNC, bus_b.V_SYNC,
                bus_b.SYNC_B, bus_b.SYNC_BLANK, bus_b.frame_start,
                bus_b.r, bus_b.g, bus_b.b, bus_b.mem_addr);
    end
  end

  // Asynchronous reset pulse between clock edges; pins must idle immediately.
  task automatic applyStimulus(input int sel, input int hold);
    exp_t e;
    @(posedge clk);
    #3;
    if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
    #1;
    if (sel == 0) begin
      e = expectPins(CFG_A, 0);
      checkPins("A.rst", e, bus_a.clk_25, bus_a.H_SYNC, bus_a.V_SYNC, bus_a.SYNC_B,
                bus_a.SYNC_BLANK, bus_a.frame_start, bus_a.r, bus_a.g, bus_a.b, bus_a.mem_addr);
    end else begin
      e = expectPins(CFG_B, 0);
      checkPins("B.rst", e, bus_b.clk_25, bus_b.H_SYNC, bus_b.V_SYNC, bus_b.SYNC_B,
                bus_b.SYNC_BLANK, bus_b.frame_start, bus_b.r, bus_b.g, bus_b.b, bus_b.mem_addr);
    end
    repeat (hold) @(negedge clk);
    #2;
    if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  initial begin
    int hs_low, vis_high, first, period, q, h, v, hs_start, vs_start;
    bit found;

    for (int i = 0; i < IMG_WORDS; i++) image[i] = 8'($urandom);
    image[0] = 8'hE0;
    image[1] = 8'h03;
    image[2] = 8'hFF;
    image[3] = 8'h00;

    @(posedge clk);
    #2 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    $display("[TB] reset released, scanning two full lines on the 640x480 instance");

    hs_low = 0;
    vis_high = 0;
    repeat (3205) begin
      @(negedge clk);
      if (bus_a.H_SYNC === 1'b0) hs_low++;
      if (bus_a.SYNC_BLANK === 1'b1) vis_high++;
    end
    checkOutput("A.hsync_low_clks", hs_low, 2 * 96 * 2);
    checkOutput("A.visible_clks", vis_high, 2 * 640 * 2);

    $display("[TB] reset pulse in the middle of a line");
    repeat ($urandom_range(200, 1500)) @(posedge clk);
    applyStimulus(0, $urandom_range(2, 6));
    repeat (1700) @(posedge clk);

    first = -1;
    period = -1;
    for (int k = 0; k < 5000 && period < 0; k++) begin
      @(negedge clk);
      if (bus_b.frame_start === 1'b1) begin
        if (first < 0) first = k;
        else period = k - first;
      end
    end
    checkOutput("B.frame_period_clks", period, 2 * 48 * 23);

    $display("[TB] reset while both syncs are asserted");
    hs_start = CFG_B.h_act + CFG_B.h_fp;
    vs_start = CFG_B.v_act + CFG_B.v_fp;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (n_b >= 6) begin
        q = (n_b - 2) / 2 - 2;
        h = q % 48;
        v = (q / 48) % 23;
        found = (h >= hs_start) && (h < hs_start + 2) && (v >= vs_start) && (v < vs_start + CFG_B.v_sw);
      end
    end
    checkOutput("B.sync_window_reached", 32'(found), 32'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    checkOutput("B.syncs_low_before_rst", {30'd0, bus_b.H_SYNC, bus_b.V_SYNC}, 32'd0);
    applyStimulus(1, $urandom_range(2, 5));
    repeat (2500) @(posedge clk);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
